// File: rtl/fetch_stage.sv
// Instruction fetch stage and IF/ID register for a sync RAM with 1-cycle read latency.
// A one-entry hold buffer keeps the in-flight RAM response from being lost during a stall.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// S_REFILL | no response in flight (after reset or redirect); IF/ID gets a bubble
// S_RUN    | response for rsp_pc_q is on imem_rdata this cycle
// S_HOLD   | response captured in the hold buffer; RAM re-reads pc_q, ignored

module fetch_stage #(
  parameter int                XLEN      = 32,
  parameter logic [XLEN-1:0]   RESET_PC  = '0,
  parameter logic [31:0]       NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcStall,
  input  logic            pcFromTaken,
  input  logic [XLEN-1:0] taken_target,
  input  logic            IF_ID_stall,
  input  logic            IF_ID_flush,
  output logic            imem_en,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid
);

  typedef enum logic [1:0] {S_REFILL, S_RUN, S_HOLD} state_t;

  state_t          state_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rsp_pc_q;
  logic [XLEN-1:0] hold_pc_q;
  logic [31:0]     hold_instr_q;

  logic            stall;
  logic            rsp_valid;
  logic            hold_valid;
  logic [XLEN-1:0] src_pc;
  logic [31:0]     src_instr;

  assign stall      = pcStall | IF_ID_stall;
  assign rsp_valid  = (state_q == S_RUN);
  assign hold_valid = (state_q == S_HOLD);
  assign imem_en    = ~rst;
  assign imem_addr  = pc_q;

  always_comb begin
    src_pc    = rsp_pc_q;
    src_instr = imem_rdata;
    if (hold_valid) begin
      src_pc    = hold_pc_q;
      src_instr = hold_instr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REFILL;
      pc_q         <= RESET_PC;
      rsp_pc_q     <= '0;
      hold_pc_q    <= '0;
      hold_instr_q <= NOP_INSTR;
      if_id_valid  <= 1'b0;
      if_id_pc     <= '0;
      if_id_instr  <= NOP_INSTR;
    end else if (pcFromTaken) begin
      // Redirect drops both the in-flight and the held fetch.
      state_q     <= S_REFILL;
      pc_q        <= {taken_target[XLEN-1:2], 2'b00};
      if_id_valid <= 1'b0;
      if_id_instr <= NOP_INSTR;
    end else begin
      case (state_q)
        S_REFILL: begin
          state_q     <= S_RUN;
          pc_q        <= pc_q + XLEN'(4);
          rsp_pc_q    <= pc_q;
          if_id_valid <= 1'b0;
          if_id_instr <= NOP_INSTR;
        end
        S_RUN, S_HOLD: begin
          if (stall) begin
            if (rsp_valid) begin
              hold_pc_q    <= rsp_pc_q;
              hold_instr_q <= imem_rdata;
            end
            state_q <= S_HOLD;
          end else begin
            state_q  <= S_RUN;
            pc_q     <= pc_q + XLEN'(4);
            rsp_pc_q <= pc_q;
          end
          // Flush invalidates IF/ID but leaves the PC path alone.
          if (IF_ID_flush) begin
            if_id_valid <= 1'b0;
            if_id_instr <= NOP_INSTR;
          end else if (!stall) begin
            if_id_valid <= 1'b1;
            if_id_pc    <= src_pc;
            if_id_instr <= src_instr;
          end
        end
        default: state_q <= S_REFILL;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Testbench for fetch_stage: directed scenarios plus randomized hazard traffic,
// checked against a stream-level model (next PC to deliver, primed flag).

module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        pcStall;
  logic        pcFromTaken;
  logic [31:0] taken_target;
  logic        IF_ID_stall;
  logic        IF_ID_flush;

  logic        imem_en,  imem_en2;
  logic [31:0] imem_addr, imem_addr2;
  logic [31:0] imem_rdata, imem_rdata2;
  logic [31:0] if_id_pc, if_id_pc2;
  logic [31:0] if_id_instr, if_id_instr2;
  logic        if_id_valid, if_id_valid2;

  int n_total = 0;
  int n_bad   = 0;

  // model state
  bit          m_primed;
  logic [31:0] m_next;
  logic        m_valid;
  logic [31:0] m_pc;
  logic [31:0] m_instr;

  fetch_stage dut (
    .clk(clk), .rst(rst), .pcStall(pcStall), .pcFromTaken(pcFromTaken),
    .taken_target(taken_target), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst(rst), .pcStall(pcStall), .pcFromTaken(pcFromTaken),
    .taken_target(taken_target), .IF_ID_stall(IF_ID_stall), .IF_ID_flush(IF_ID_flush),
    .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
    .if_id_pc(if_id_pc2), .if_id_instr(if_id_instr2), .if_id_valid(if_id_valid2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h0000_0013;
      32'h4:   return 32'h0010_0093;
      32'h8:   return 32'h0020_0113;
      32'hC:   return 32'h0030_0193;
      default: return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endcase
  endfunction

  always @(posedge clk) begin
    if (imem_en)  imem_rdata  <= mem_word(imem_addr);
    if (imem_en2) imem_rdata2 <= mem_word(imem_addr2);
  end

  task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Stream-level reference: after reset/redirect one forced bubble, then each
  // unstalled edge delivers m_next and moves on by 4.
  task automatic model_edge();
    if (rst) begin
      m_primed = 1'b0;
      m_next   = 32'h0;
      m_valid  = 1'b0;
      m_pc     = 32'h0;
      m_instr  = NOP;
    end else if (pcFromTaken) begin
      m_primed = 1'b0;
      m_next   = taken_target & 32'hFFFF_FFFC;
      m_valid  = 1'b0;
      m_instr  = NOP;
    end else if (!m_primed) begin
      m_primed = 1'b1;
      m_valid  = 1'b0;
      m_instr  = NOP;
    end else if (!(pcStall || IF_ID_stall)) begin
      if (IF_ID_flush) begin
        m_valid = 1'b0;
        m_instr = NOP;
      end else begin
        m_valid = 1'b1;
        m_pc    = m_next;
        m_instr = mem_word(m_next);
      end
      m_next = m_next + 32'd4;
    end else if (IF_ID_flush) begin
      m_valid = 1'b0;
      m_instr = NOP;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk_val("m_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
    chk_val("m_instr", if_id_instr, m_instr);
    chk_val("m_pc", if_id_pc, m_pc);
    chk_val("imem_en", {31'b0, imem_en}, {31'b0, ~rst});
  endtask

  task automatic expect_if(input string tag, input logic v, input logic [31:0] pc,
                           input logic [31:0] instr);
    chk_val({tag, "_valid"}, {31'b0, if_id_valid}, {31'b0, v});
    chk_val({tag, "_instr"}, if_id_instr, instr);
    if (v) chk_val({tag, "_pc"}, if_id_pc, pc);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pcStall = 1'b0; pcFromTaken = 1'b0; taken_target = '0;
    IF_ID_stall = 1'b0; IF_ID_flush = 1'b0;
    m_primed = 1'b0; m_next = '0; m_valid = 1'b0; m_pc = '0; m_instr = NOP;
    @(negedge clk);

    // reset and free run, with the wrap-around instance alongside
    do_reset(2);
    chk_val("rst_valid", {31'b0, if_id_valid}, 32'h0);
    chk_val("rst_instr", if_id_instr, NOP);
    chk_val("rst_pc", if_id_pc, 32'h0);
    step(); expect_if("run_bubble", 1'b0, 32'h0, NOP);
    step(); expect_if("run0", 1'b1, 32'h0, 32'h0000_0013);
    chk_val("wrap0", if_id_pc2, 32'hFFFF_FFF8);
    step(); expect_if("run4", 1'b1, 32'h4, 32'h0010_0093);
    chk_val("wrap1", if_id_pc2, 32'hFFFF_FFFC);
    step(); expect_if("run8", 1'b1, 32'h8, 32'h0020_0113);
    chk_val("wrap2", if_id_pc2, 32'h0);
    chk_val("wrap2_valid", {31'b0, if_id_valid2}, 32'h1);
    step(); expect_if("run12", 1'b1, 32'hC, 32'h0030_0193);

    // two-cycle stall while pc 4 is in decode
    do_reset(1);
    step(); step(); step();
    expect_if("stall_a", 1'b1, 32'h4, 32'h0010_0093);
    pcStall = 1'b1; IF_ID_stall = 1'b1;
    step(); expect_if("stall_b", 1'b1, 32'h4, 32'h0010_0093);
    step(); expect_if("stall_c", 1'b1, 32'h4, 32'h0010_0093);
    pcStall = 1'b0; IF_ID_stall = 1'b0;
    step(); expect_if("stall_rel8", 1'b1, 32'h8, 32'h0020_0113);
    step(); expect_if("stall_rel12", 1'b1, 32'hC, 32'h0030_0193);

    // redirect while streaming at 0x10
    do_reset(1);
    repeat (6) step();
    chk_val("pre_taken_pc", if_id_pc, 32'h10);
    pcFromTaken = 1'b1; taken_target = 32'h40;
    step(); expect_if("taken_t1", 1'b0, 32'h0, NOP);
    pcFromTaken = 1'b0;
    step(); expect_if("taken_t2", 1'b0, 32'h0, NOP);
    step(); expect_if("taken_t3", 1'b1, 32'h40, mem_word(32'h40));
    step(); expect_if("taken_t4", 1'b1, 32'h44, mem_word(32'h44));

    // redirect beats stall and flush with a held entry present
    pcStall = 1'b1; IF_ID_stall = 1'b1;
    step();
    pcFromTaken = 1'b1; taken_target = 32'h40; IF_ID_flush = 1'b1;
    step(); expect_if("tkst_t1", 1'b0, 32'h0, NOP);
    pcFromTaken = 1'b0; pcStall = 1'b0; IF_ID_stall = 1'b0; IF_ID_flush = 1'b0;
    step(); expect_if("tkst_t2", 1'b0, 32'h0, NOP);
    step(); expect_if("tkst_t3", 1'b1, 32'h40, mem_word(32'h40));
    step(); expect_if("tkst_t4", 1'b1, 32'h44, mem_word(32'h44));

    // unaligned target is forced to word alignment
    pcFromTaken = 1'b1; taken_target = 32'h43;
    step(); chk_val("align_addr", imem_addr, 32'h40);
    pcFromTaken = 1'b0;
    step(); step(); expect_if("align_t3", 1'b1, 32'h40, mem_word(32'h40));

    // reset during a stall with a held entry
    step();
    pcStall = 1'b1; IF_ID_stall = 1'b1;
    step();
    rst = 1'b1;
    step(); expect_if("rsthold_t1", 1'b0, 32'h0, NOP);
    chk_val("rsthold_pc", if_id_pc, 32'h0);
    rst = 1'b0; pcStall = 1'b0; IF_ID_stall = 1'b0;
    step(); expect_if("rsthold_t2", 1'b0, 32'h0, NOP);
    step(); expect_if("rsthold_t3", 1'b1, 32'h0, 32'h0000_0013);

    // randomized hazard traffic against the model
    for (int i = 0; i < 3000; i++) begin
      rst          = ($urandom % 64) == 0;
      pcFromTaken  = ($urandom % 12) == 0;
      pcStall      = ($urandom % 5) == 0;
      IF_ID_stall  = ($urandom % 7) == 0;
      IF_ID_flush  = ($urandom % 9) == 0;
      case ($urandom % 3)
        0:       taken_target = $urandom;
        1:       taken_target = 32'hFFFF_FFF0 + $urandom_range(0, 15);
        default: taken_target = $urandom_range(0, 255);
      endcase
      step();
    end

    rst = 1'b0; pcFromTaken = 1'b0; pcStall = 1'b0; IF_ID_stall = 1'b0; IF_ID_flush = 1'b0;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
